riscv_regfile_sb: RTL and testbench
===================================

Name: riscv_regfile_sb

Overview:
- Integer register file with a pending-write scoreboard. It is the receiving end of the writeback interface (write enable, destination index, write data).
- ID stage reads rs1/rs2 and reserves rd at issue; WB retires the reservation when it writes.
- Provides operand data with write-first bypass, plus busy/stall flags to the hazard unit.

Parameters:
- XLEN, `XLEN (32): register data width.
- N_REG, 32: number of architectural registers; index width is 5.
- CNT_W, 2: per-register pending-write counter width; max in-flight writes to one rd is 2^CNT_W-1 = 3.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_wr_en  in  1  writeback write enable.
- i_wr_rd  in  5  writeback destination index.
- i_wr_data  in  XLEN  writeback data.
- i_rs1  in  5  source 1 index.
- i_rs2  in  5  source 2 index.
- o_rs1_data  out  XLEN  source 1 data, combinational.
- o_rs2_data  out  XLEN  source 2 data, combinational.
- i_rsv_en  in  1  ID issues an instruction that writes rd.
- i_rsv_rd  in  5  rd to reserve.
- i_flush  in  1  squash: clear all pending counters.
- o_rs1_busy  out  1  rs1 has a pending write.
- o_rs2_busy  out  1  rs2 has a pending write.
- o_rsv_full  out  1  i_rsv_rd counter at max.
- o_stall  out  1  o_rs1_busy | o_rs2_busy | (i_rsv_en & o_rsv_full).

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous and active-high. On reset, all registers and all counters are 0.
  - Outputs one cycle after reset: read data = 0 unless bypassed; busy = 0; full = 0; stall = 0.
  - Reset asserted mid-operation discards all pending state. A write presented in the same cycle as reset is dropped.
- Register write: at posedge, if i_wr_en & i_wr_rd != 0, then reg[i_wr_rd] <= i_wr_data. Writes to x0 are ignored.
- Register read: combinational.
  - rsN == 0 -> data 0.
  - Else if i_wr_en & i_wr_rd == rsN -> i_wr_data (write-first bypass).
  - Else reg[rsN].
- Pending counter cnt[r], for r = 1..31 (x0 has no counter; it is never busy and never full):
  - inc = i_rsv_en & !o_stall & i_rsv_rd == r & r != 0.
  - dec = i_wr_en & i_wr_rd == r & cnt[r] != 0. A write with cnt = 0 (stale after flush, or unreserved) leaves cnt at 0.
  - inc & dec -> hold; inc only -> +1; dec only -> -1.
  - i_flush: all cnt <= 0 next cycle. Flush has priority over inc; a same-cycle WB write still updates the register.
- Busy (this-cycle view, so WB and ID do not deadlock): rsN_busy = rsN != 0 & (cnt[rsN] > 1 | (cnt[rsN] == 1 & !(i_wr_en & i_wr_rd == rsN))).
- Full: o_rsv_full = cnt[i_rsv_rd] == 2^CNT_W-1, with no same-cycle decrement to i_rsv_rd.
- Stall gating: when o_stall = 1, the reservation is not taken. ID holds the instruction and re-presents it.
- Latency: read 0 cycles; write visible via bypass in the same cycle and from the register array the next cycle; busy clears in the same cycle as the final WB write.

Decomposition:
- Shared config header riscv_configs.v gains: `XLEN (existing), `REG_ADDR_W = 5, `N_REG = 32, `SB_CNT_W = 2.
- Sub-module riscv_sb_cnt: one saturating up/down counter with sync clear and inc/dec/clr inputs. Its outputs are cnt, zero and max.
  - Instantiated 31 times via generate in riscv_regfile_sb.
- Read bypass muxes stay inline.

Test Plan:
- Reset: assert i_rst 2 cycles after random writes -> reading x1..x31 gives 0; all busy = 0; o_stall = 0.
- x0: wr_en=1, rd=0, data=0xDEADBEEF; rsv_en=1, rsv_rd=0 -> o_rs1_data(rs1=0) = 0; rs1_busy = 0 every cycle.
- Bypass and retire: reserve x5 at cycle 0 -> rs1=x5 busy at cycles 1-2, o_stall=1. At cycle 3, WB writes x5=0x12345678 -> same cycle o_rs1_data=0x12345678, busy=0, stall=0.
- Multiple in flight: reserve x7 three times, then fourth rsv_en -> o_rsv_full=1, o_stall=1, count stays 3. Three WB writes to x7 -> busy stays 1 until the third write, then 0.
- Simultaneous: cnt[x9]=1; same cycle rsv x9 and WB write x9 -> cnt stays 1, busy next cycle = 1. Flush with cnt[x9]=2 -> cnt 0 next cycle; later WB write to x9 updates data, cnt stays 0.

Source files
------------

// File: rtl/riscv_regfile_sb_pkg.sv
// Shared configuration macros and package for the register file with pending-write scoreboard.
// The macros are guarded so an existing riscv_configs definition of XLEN takes precedence.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef N_REG
`define N_REG 32
`endif
`ifndef SB_CNT_W
`define SB_CNT_W 2
`endif

package riscv_regfile_sb_pkg;

    localparam int XLEN_DEF   = `XLEN;
    localparam int REG_ADDR_W = `REG_ADDR_W;
    localparam int N_REG_DEF  = `N_REG;
    localparam int SB_CNT_W   = `SB_CNT_W;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    // A register is busy unless its only outstanding write is retiring this cycle.
    function automatic logic sb_busy(input logic [SB_CNT_W-1:0] cnt, input logic wr_hit);
        logic more_than_one;
        logic exactly_one;
        more_than_one = (cnt > SB_CNT_W'(1));
        exactly_one   = (cnt == SB_CNT_W'(1));
        return more_than_one | (exactly_one & ~wr_hit);
    endfunction

endpackage

// File: rtl/riscv_sb_cnt.sv
// Saturating up/down pending-write counter for one architectural register.
// Clear wins over inc/dec; simultaneous inc and dec hold the count.
module riscv_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             max
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && !dec && !max) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign max  = (cnt_q == '1);

endmodule

// File: rtl/riscv_regfile_sb.sv
// Integer register file with write-first bypass and a per-register pending-write scoreboard.
// ID reserves rd at issue; the WB write to rd retires one reservation.
module riscv_regfile_sb
    import riscv_regfile_sb_pkg::*;
#(
    parameter int XLEN  = `XLEN,
    parameter int N_REG = `N_REG,
    parameter int CNT_W = `SB_CNT_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [REG_ADDR_W-1:0] i_wr_rd,
    input  logic [XLEN-1:0]       i_wr_data,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic [XLEN-1:0]       o_rs1_data,
    output logic [XLEN-1:0]       o_rs2_data,
    input  logic                  i_rsv_en,
    input  logic [REG_ADDR_W-1:0] i_rsv_rd,
    input  logic                  i_flush,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic                  o_rsv_full,
    output logic                  o_stall
);

    logic [XLEN-1:0]  regs    [N_REG];
    logic [CNT_W-1:0] sb_cnt  [N_REG];
    logic             sb_zero [N_REG];
    logic             sb_max  [N_REG];

    logic wr_live;
    logic wr_hit_rs1;
    logic wr_hit_rs2;
    logic wr_hit_rsv;

    assign wr_live    = i_wr_en && (i_wr_rd != '0);
    assign wr_hit_rs1 = wr_live && (i_wr_rd == i_rs1);
    assign wr_hit_rs2 = wr_live && (i_wr_rd == i_rs2);
    assign wr_hit_rsv = wr_live && (i_wr_rd == i_rsv_rd);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[i_wr_rd] <= i_wr_data;
        end
    end

    always_comb begin
        o_rs1_data = '0;
        if (i_rs1 != '0) begin
            o_rs1_data = wr_hit_rs1 ? i_wr_data : regs[i_rs1];
        end
    end

    always_comb begin
        o_rs2_data = '0;
        if (i_rs2 != '0) begin
            o_rs2_data = wr_hit_rs2 ? i_wr_data : regs[i_rs2];
        end
    end

    // Reservation handshake: i_rsv_en is a request that is accepted only in a
    // cycle where o_stall is low; while stalled, ID holds and re-presents it.
    // x0 has no counter: it reads as an empty, never-full slot.
    assign sb_cnt[0]  = '0;
    assign sb_zero[0] = 1'b1;
    assign sb_max[0]  = 1'b0;

    for (genvar r = 1; r < N_REG; r++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = i_rsv_en && !o_stall && (i_rsv_rd == REG_ADDR_W'(r));
        assign dec = i_wr_en && (i_wr_rd == REG_ADDR_W'(r)) && !sb_zero[r];

        riscv_sb_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk  (i_clk),
            .rst  (i_rst),
            .clr  (i_flush),
            .inc  (inc),
            .dec  (dec),
            .cnt  (sb_cnt[r]),
            .zero (sb_zero[r]),
            .max  (sb_max[r])
        );
    end

    assign o_rs1_busy = (i_rs1 != '0) && sb_busy(sb_cnt[i_rs1], wr_hit_rs1);
    assign o_rs2_busy = (i_rs2 != '0) && sb_busy(sb_cnt[i_rs2], wr_hit_rs2);
    assign o_rsv_full = sb_max[i_rsv_rd] && !wr_hit_rsv;
    assign o_stall    = o_rs1_busy || o_rs2_busy || (i_rsv_en && o_rsv_full);

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Directed bench for riscv_regfile_sb: drivers push expected outputs into a queue
// that a negedge monitor pops and compares against the DUT.
module tb_riscv_regfile_sb;

    localparam int XLEN = 32;
    localparam int EW   = 2 * XLEN + 4;

    logic            i_clk;
    logic            i_rst;
    logic            i_wr_en;
    logic [4:0]      i_wr_rd;
    logic [XLEN-1:0] i_wr_data;
    logic [4:0]      i_rs1;
    logic [4:0]      i_rs2;
    logic [XLEN-1:0] o_rs1_data;
    logic [XLEN-1:0] o_rs2_data;
    logic            i_rsv_en;
    logic [4:0]      i_rsv_rd;
    logic            i_flush;
    logic            o_rs1_busy;
    logic            o_rs2_busy;
    logic            o_rsv_full;
    logic            o_stall;

    riscv_regfile_sb dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (i_wr_en),
        .i_wr_rd    (i_wr_rd),
        .i_wr_data  (i_wr_data),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .o_rs1_data (o_rs1_data),
        .o_rs2_data (o_rs2_data),
        .i_rsv_en   (i_rsv_en),
        .i_rsv_rd   (i_rsv_rd),
        .i_flush    (i_flush),
        .o_rs1_busy (o_rs1_busy),
        .o_rs2_busy (o_rs2_busy),
        .o_rsv_full (o_rsv_full),
        .o_stall    (o_stall)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // scoreboard
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    always @(negedge i_clk) begin
        while (exp_q.size() > 0) begin
            logic [EW-1:0] exp_v;
            logic [EW-1:0] got_v;
            string         nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            got_v = {o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_rsv_full, o_stall};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got rs1=%h rs2=%h b1=%b b2=%b full=%b stall=%b, want rs1=%h rs2=%h b1=%b b2=%b full=%b stall=%b",
                         nm, got_v[EW-1 -: XLEN], got_v[XLEN+3 -: XLEN], got_v[3], got_v[2], got_v[1], got_v[0],
                         exp_v[EW-1 -: XLEN], exp_v[XLEN+3 -: XLEN], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wrd, input logic [XLEN-1:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic re, input logic [4:0] rrd,
                         input logic fl, input logic rs);
        i_wr_en   = we;
        i_wr_rd   = wrd;
        i_wr_data = wd;
        i_rs1     = r1;
        i_rs2     = r2;
        i_rsv_en  = re;
        i_rsv_rd  = rrd;
        i_flush   = fl;
        i_rst     = rs;
    endtask

    task automatic expect_out(input string nm, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                              input logic b1, input logic b2, input logic full, input logic stall);
        exp_q.push_back({d1, d2, b1, b2, full, stall});
        name_q.push_back(nm);
    endtask

    logic [XLEN-1:0] vals [32];

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset state
        tick();
        drive(0, 0, 0, 1, 31, 0, 0, 0, 0);
        expect_out("reset_state", 0, 0, 0, 0, 0, 0);

        // fill x1..x31, checking bypass and the previously written register
        vals[0] = '0;
        for (int i = 1; i < 32; i++) begin
            vals[i] = $urandom;
            tick();
            drive(1, 5'(i), vals[i], 5'(i), 5'(i - 1), 0, 0, 0, 0);
            expect_out("wr_bypass", vals[i], vals[i - 1], 0, 0, 0, 0);
        end
        for (int i = 1; i < 32; i++) begin
            tick();
            drive(0, 0, 0, 5'(i), 5'(32 - i), 0, 0, 0, 0);
            expect_out("readback", vals[i], vals[32 - i], 0, 0, 0, 0);
        end

        // reserve x11, then reset for 2 cycles with a write and reservation that must be dropped
        tick();
        drive(0, 0, 0, 0, 0, 1, 11, 0, 0);
        expect_out("rsv_x11", 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 11, 0, 0, 0, 0, 0);
        expect_out("x11_busy", vals[11], 0, 1, 0, 0, 1);
        tick();
        drive(1, 3, 32'hFFFF_FFFF, 0, 0, 1, 3, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i < 32; i++) begin
            tick();
            drive(0, 0, 0, 5'(i), 11, 0, 0, 0, 0);
            expect_out("post_reset", 0, 0, 0, 0, 0, 0);
        end
        tick();
        drive(0, 0, 0, 3, 3, 0, 3, 0, 0);
        expect_out("reset_drops_rsv", 0, 0, 0, 0, 0, 0);

        // x0 never written, never busy, never full
        tick();
        drive(1, 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0);
        expect_out("x0_write", 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0);
        expect_out("x0_rsv", 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("x0_read", 0, 0, 0, 0, 0, 0);

        // bypass and retire on x5
        tick();
        drive(0, 0, 0, 5, 0, 1, 5, 0, 0);
        expect_out("x5_rsv", 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 5, 0, 0, 0, 0, 0);
        expect_out("x5_busy_c1", 0, 0, 1, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 5, 0, 0, 0, 0);
        expect_out("x5_busy_c2", 0, 0, 0, 1, 0, 1);
        tick();
        drive(1, 5, 32'h1234_5678, 5, 0, 0, 0, 0, 0);
        expect_out("x5_retire", 32'h1234_5678, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 5, 5, 0, 0, 0, 0);
        expect_out("x5_after", 32'h1234_5678, 32'h1234_5678, 0, 0, 0, 0);

        // three in flight on x7, fourth is refused
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(0, 0, 0, 0, 0, 1, 7, 0, 0);
            expect_out("x7_rsv", 0, 0, 0, 0, 0, 0);
        end
        tick();
        drive(0, 0, 0, 0, 0, 1, 7, 0, 0);
        expect_out("x7_full", 0, 0, 0, 0, 1, 1);
        tick();
        drive(0, 0, 0, 7, 0, 0, 7, 0, 0);
        expect_out("x7_busy", 0, 0, 1, 0, 1, 1);
        tick();
        drive(1, 7, 32'hA, 7, 0, 0, 7, 0, 0);
        expect_out("x7_wb1", 32'hA, 0, 1, 0, 0, 1);
        tick();
        drive(1, 7, 32'hB, 7, 0, 0, 7, 0, 0);
        expect_out("x7_wb2", 32'hB, 0, 1, 0, 0, 1);
        tick();
        drive(1, 7, 32'hC, 7, 0, 0, 7, 0, 0);
        expect_out("x7_wb3", 32'hC, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 7, 0, 0, 7, 0, 0);
        expect_out("x7_idle", 32'hC, 0, 0, 0, 0, 0);

        // simultaneous reserve and retire on x9, then flush
        tick();
        drive(0, 0, 0, 0, 0, 1, 9, 0, 0);
        expect_out("x9_rsv", 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 9, 32'hD, 9, 0, 1, 9, 0, 0);
        expect_out("x9_rsv_and_wb", 32'hD, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 9, 0, 0, 0, 0);
        expect_out("x9_still_busy", 0, 32'hD, 0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 9, 0, 0);
        expect_out("x9_rsv2", 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 9, 1, 0);
        expect_out("x9_flush", 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 9, 0, 0, 0, 0, 0);
        expect_out("x9_flushed", 32'hD, 0, 0, 0, 0, 0);
        tick();
        drive(1, 9, 32'hE, 9, 0, 0, 0, 0, 0);
        expect_out("x9_stale_wb", 32'hE, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 9, 9, 0, 9, 0, 0);
        expect_out("x9_cnt_zero", 32'hE, 32'hE, 0, 0, 0, 0);

        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge i_clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
